// File: rtl/or1200_vlx_packer.sv
`default_nettype none
// ============================================================================
// Module      : or1200_vlx_packer
// Description : Variable-length bit packer. Appends right-justified bit fields
//               MSB-first into an accumulator and emits completed bytes as
//               byte stores, with optional 0xFF byte stuffing and a flush
//               that pads the last partial byte with ones.
// Revision    : 1.0 - initial release
// ============================================================================
module or1200_vlx_packer #(
  parameter int ACC_W     = 32,
  parameter int MAXBITS   = 16,
  parameter int NB_W      = 5,
  parameter bit STUFF_DEF = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               set_bit_op_i,
  input  logic [NB_W-1:0]    num_bits_i,
  input  logic [MAXBITS-1:0] dat_i,
  output logic               stall_cpu_o,
  output logic               store_byte_o,
  output logic [31:0]        vlx_addr_o,
  output logic [7:0]         dat_o,
  input  logic               ack_i,
  input  logic               spr_cs,
  input  logic               spr_write,
  input  logic [1:0]         spr_addr,
  input  logic [31:0]        spr_dat_i,
  output logic [31:0]        spr_dat_o
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_STUFF = 2'd2,
    S_PAD   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               stuff_en_q, stuff_en_d;

  logic [NB_W-1:0]    nb_clip;
  logic [CNT_W-1:0]   n_eff;
  logic               accept;
  logic               spr_we;
  logic               flush;
  logic [ACC_W-1:0]   ins_bits;
  logic [CNT_W-1:0]   ins_shamt;
  logic [ACC_W-1:0]   acc_app;
  logic [CNT_W-1:0]   cnt_app;
  logic [CNT_W-1:0]   cnt_up;
  logic [ACC_W-1:0]   pad_fill;
  logic [7:0]         top_byte;
  logic [31:0]        acc_top32;

  // Requested length is clipped to MAXBITS; a zero length is not an accept.
  assign nb_clip   = (num_bits_i > NB_W'(MAXBITS)) ? NB_W'(MAXBITS) : num_bits_i;
  assign n_eff     = CNT_W'(nb_clip);
  assign accept    = (state_q == S_IDLE) && set_bit_op_i && (n_eff != '0);
  assign spr_we    = spr_cs && spr_write && (state_q == S_IDLE);
  assign flush     = spr_we && (spr_addr == 2'd2) && spr_dat_i[0];

  // New field lands just below the current valid bits.
  assign ins_bits  = {{(ACC_W-MAXBITS){1'b0}}, dat_i} & ~({ACC_W{1'b1}} << n_eff);
  assign ins_shamt = CNT_W'(ACC_W) - cnt_q - n_eff;
  assign acc_app   = accept ? (acc_q | (ins_bits << ins_shamt)) : acc_q;
  assign cnt_app   = accept ? (cnt_q + n_eff) : cnt_q;

  // Ones from the first empty bit up to the next byte boundary.
  assign cnt_up    = (cnt_q + CNT_W'(7)) & ~CNT_W'(7);
  assign pad_fill  = ({ACC_W{1'b1}} >> cnt_q) & ~({ACC_W{1'b1}} >> cnt_up);

  assign top_byte  = acc_q[ACC_W-1 -: 8];

  // SPR3 view of the accumulator head, zero-extended for narrow builds.
  generate
    if (ACC_W >= 32) begin : g_acc_wide
      assign acc_top32 = acc_q[ACC_W-1 -: 32];
    end else begin : g_acc_narrow
      assign acc_top32 = {{(32-ACC_W){1'b0}}, acc_q};
    end
  endgenerate

  // Next-state computation for the packer FSM and its datapath.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    stuff_en_d = stuff_en_q;
    case (state_q)
      S_IDLE: begin
        acc_d = acc_app;
        cnt_d = cnt_app;
        if (spr_we && (spr_addr == 2'd0)) addr_d = spr_dat_i;
        if (spr_we && (spr_addr == 2'd2)) stuff_en_d = spr_dat_i[1];
        if (flush && (cnt_app[2:0] != 3'd0)) state_d = S_PAD;
        else if (cnt_app >= CNT_W'(8))       state_d = S_STORE;
      end
      S_STORE: begin
        if (ack_i) begin
          acc_d  = acc_q << 8;
          cnt_d  = cnt_q - CNT_W'(8);
          addr_d = addr_q + 32'd1;
          if (stuff_en_q && (top_byte == 8'hFF))  state_d = S_STUFF;
          else if (cnt_q - CNT_W'(8) >= CNT_W'(8)) state_d = S_STORE;
          else                                     state_d = S_IDLE;
        end
      end
      S_STUFF: begin
        if (ack_i) begin
          addr_d  = addr_q + 32'd1;
          state_d = (cnt_q >= CNT_W'(8)) ? S_STORE : S_IDLE;
        end
      end
      S_PAD: begin
        acc_d   = acc_q | pad_fill;
        cnt_d   = cnt_up;
        state_d = S_STORE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any pending byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      stuff_en_q <= STUFF_DEF;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      stuff_en_q <= stuff_en_d;
    end
  end

  assign store_byte_o = (state_q == S_STORE) || (state_q == S_STUFF);
  assign dat_o        = (state_q == S_STORE) ? top_byte : 8'h00;
  assign vlx_addr_o   = addr_q;
  assign stall_cpu_o  = (state_q != S_IDLE) || (accept && (cnt_app >= CNT_W'(8)));

  // Combinational SPR read mux.
  always_comb begin
    spr_dat_o = 32'd0;
    case (spr_addr)
      2'd0: spr_dat_o = addr_q;
      2'd1: spr_dat_o = {(state_q != S_IDLE), {(31-CNT_W){1'b0}}, cnt_q};
      2'd2: spr_dat_o = {30'd0, stuff_en_q, 1'b0};
      2'd3: spr_dat_o = acc_top32;
      default: spr_dat_o = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_or1200_vlx_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_or1200_vlx_packer
// Description : Bench for or1200_vlx_packer against a bit-queue / byte-queue
//               reference model, with directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or1200_vlx_packer;
  localparam int MAXBITS = 16;
  localparam int NB_W    = 5;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               set_bit_op_i = 1'b0;
  logic [NB_W-1:0]    num_bits_i = '0;
  logic [MAXBITS-1:0] dat_i = '0;
  logic               ack_i = 1'b0;
  logic               spr_cs = 1'b0;
  logic               spr_write = 1'b0;
  logic [1:0]         spr_addr = 2'd0;
  logic [31:0]        spr_dat_i = 32'd0;
  logic               stall_cpu_o, store_byte_o;
  logic [31:0]        vlx_addr_o, spr_dat_o;
  logic [7:0]         dat_o;

  or1200_vlx_packer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .set_bit_op_i(set_bit_op_i),
    .num_bits_i(num_bits_i), .dat_i(dat_i), .stall_cpu_o(stall_cpu_o),
    .store_byte_o(store_byte_o), .vlx_addr_o(vlx_addr_o), .dat_o(dat_o),
    .ack_i(ack_i), .spr_cs(spr_cs), .spr_write(spr_write),
    .spr_addr(spr_addr), .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: leftover bits, queue of pending stores, address counter.
  typedef struct { logic [31:0] a; logic [7:0] d; bit stuff; } st_t;
  bit          mbits[$];
  st_t         mq[$];
  st_t         log_q[$];
  logic [31:0] m_addr;
  bit          m_stuff;
  bit          m_pad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbits.delete(); mq.delete();
    m_addr = 32'd0; m_stuff = 1'b1; m_pad = 1'b0;
  endtask

  task automatic drain();
    logic [7:0] b;
    while (mbits.size() >= 8) begin
      for (int i = 7; i >= 0; i--) b[i] = mbits.pop_front();
      mq.push_back('{a: m_addr, d: b, stuff: 1'b0}); m_addr++;
      if (m_stuff && b == 8'hFF) begin
        mq.push_back('{a: m_addr, d: 8'h00, stuff: 1'b1}); m_addr++;
      end
    end
  endtask

  function automatic int neff();
    return (int'(num_bits_i) > MAXBITS) ? MAXBITS : int'(num_bits_i);
  endfunction

  function automatic logic [31:0] cur_addr();
    return (mq.size() > 0) ? mq[0].a : m_addr;
  endfunction

  // Compare all meaningful DUT outputs against the model (inputs already applied).
  task automatic compare();
    bit idle, exp_store, acc_ok;
    int pos, nd;
    logic [31:0] accv;
    idle = (mq.size() == 0) && !m_pad;
    exp_store = (mq.size() > 0) && !m_pad;
    acc_ok = idle && set_bit_op_i && (neff() > 0);
    chk("store_byte", 32'(store_byte_o), 32'(exp_store));
    chk("stall", 32'(stall_cpu_o), 32'(!idle || (acc_ok && (mbits.size() + neff() >= 8))));
    if (exp_store) begin
      chk("dat_o", 32'(dat_o), 32'(mq[0].d));
      chk("vlx_addr", vlx_addr_o, mq[0].a);
    end
    case (spr_addr)
      2'd0: chk("spr0", spr_dat_o, cur_addr());
      2'd2: chk("spr2", spr_dat_o, {30'd0, m_stuff, 1'b0});
      default: if (!m_pad) begin
        nd = 0; accv = 32'd0; pos = 31;
        foreach (mq[k]) if (!mq[k].stuff) begin
          nd++;
          for (int i = 7; i >= 0; i--) begin accv[pos] = mq[k].d[i]; pos--; end
        end
        foreach (mbits[k]) begin accv[pos] = mbits[k]; pos--; end
        if (spr_addr == 2'd1)
          chk("spr1", spr_dat_o, {!idle, 31'(mbits.size() + 8 * nd)});
        else
          chk("spr3", spr_dat_o, accv);
      end
    endcase
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic model_edge();
    bit idle, exp_store;
    logic [MAXBITS-1:0] d;
    int n;
    idle = (mq.size() == 0) && !m_pad;
    exp_store = (mq.size() > 0) && !m_pad;
    m_pad = 1'b0;
    if (exp_store && ack_i) log_q.push_back(mq.pop_front());
    if (idle) begin
      if (spr_cs && spr_write && spr_addr == 2'd0) m_addr = spr_dat_i;
      if (spr_cs && spr_write && spr_addr == 2'd2) m_stuff = spr_dat_i[1];
      n = neff(); d = dat_i;
      if (set_bit_op_i && n > 0) begin
        for (int i = n - 1; i >= 0; i--) mbits.push_back(d[i]);
        drain();
      end
      if (spr_cs && spr_write && spr_addr == 2'd2 && spr_dat_i[0] && mbits.size() > 0) begin
        while (mbits.size() < 8) mbits.push_back(1'b1);
        drain();
        m_pad = 1'b1;
      end
    end
  endtask

  // One clock cycle: inputs set at the falling edge, check, then cross the edge.
  task automatic cycle();
    #1 compare();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic drive(input bit s, input int n, input logic [15:0] d, input bit a,
                       input bit cs, input bit we, input logic [1:0] sa, input logic [31:0] sd);
    set_bit_op_i = s; num_bits_i = NB_W'(n); dat_i = d; ack_i = a;
    spr_cs = cs; spr_write = we; spr_addr = sa; spr_dat_i = sd;
  endtask

  task automatic run_idle(input string nm);
    int k;
    k = 0;
    drive(0, 0, 0, 1, 0, 0, 2'd1, 0);
    while ((mq.size() > 0 || m_pad) && k < 64) begin cycle(); k++; end
    chk({nm, "_timeout"}, 32'(k >= 64), 32'd0);
    cycle();
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [31:0] a, input logic [7:0] d);
    if (log_q.size() > idx) begin
      chk({nm, "_addr"}, log_q[idx].a, a);
      chk({nm, "_dat"}, 32'(log_q[idx].d), 32'(d));
    end else chk({nm, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 2'd1, 0);
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_store", 32'(store_byte_o), 0);
    chk("rst_stall", 32'(stall_cpu_o), 0);
    chk("rst_dat", 32'(dat_o), 0);
    chk("rst_addr", vlx_addr_o, 0);
    chk("rst_spr1", spr_dat_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 2'd2, 0);
    #1 chk("rst_spr2", spr_dat_o, 32'h2);
    @(negedge clk_i);

    // Two nibbles make one byte at 0x1000.
    log_q.delete();
    drive(0, 0, 0, 0, 1, 1, 2'd0, 32'h1000); cycle();
    drive(1, 4, 16'hA, 0, 0, 0, 2'd1, 0);    cycle();
    drive(1, 4, 16'h5, 0, 0, 0, 2'd1, 0);    cycle();
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0);        cycle(); cycle();
    run_idle("s049");
    chk("s049_cnt", 32'(log_q.size()), 1);
    chk_log("s049", 0, 32'h1000, 8'hA5);
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
    #1 chk("s049_addr", spr_dat_o, 32'h1001);
    @(negedge clk_i);

    // 0xFF gets a stuffed zero after it.
    log_q.delete();
    drive(1, 16, 16'hFF12, 0, 0, 0, 2'd1, 0); cycle();
    run_idle("s050");
    chk("s050_cnt", 32'(log_q.size()), 3);
    chk_log("s050a", 0, 32'h1001, 8'hFF);
    chk_log("s050b", 1, 32'h1002, 8'h00);
    chk_log("s050c", 2, 32'h1003, 8'h12);

    // Flush pads a 3-bit remainder with ones.
    log_q.delete();
    drive(1, 3, 16'h5, 0, 0, 0, 2'd1, 0);   cycle();
    drive(0, 0, 0, 0, 1, 1, 2'd2, 32'h3);   cycle();
    run_idle("s051");
    chk_log("s051", 0, 32'h1004, 8'hBF);
    drive(0, 0, 0, 0, 0, 0, 2'd1, 0);
    #1 chk("s051_spr1", spr_dat_o, 0);
    @(negedge clk_i);

    // Address wraps past 0xFFFFFFFF.
    log_q.delete();
    drive(0, 0, 0, 0, 1, 1, 2'd0, 32'hFFFF_FFFF); cycle();
    drive(1, 8, 16'h33, 0, 0, 0, 2'd1, 0);        cycle();
    run_idle("s052");
    chk_log("s052", 0, 32'hFFFF_FFFF, 8'h33);
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
    #1 chk("s052_wrap", spr_dat_o, 0);
    @(negedge clk_i);

    // Oversized length is clipped to MAXBITS.
    log_q.delete();
    drive(1, 31, 16'hABCD, 0, 0, 0, 2'd1, 0); cycle();
    run_idle("s054");
    chk("s054_cnt", 32'(log_q.size()), 2);
    chk_log("s054a", 0, 32'h0, 8'hAB);
    chk_log("s054b", 1, 32'h1, 8'hCD);

    // Reset while a store waits for its acknowledge.
    drive(1, 8, 16'h77, 0, 0, 0, 2'd1, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 2'd1, 0);      cycle();
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("s053_store", 32'(store_byte_o), 0);
    chk("s053_stall", 32'(stall_cpu_o), 0);
    chk("s053_spr1", spr_dat_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    log_q.delete();
    drive(0, 0, 0, 1, 0, 0, 2'd1, 0);
    repeat (3) cycle();
    chk("s053_noack", 32'(log_q.size()), 0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 2) == 0), $urandom_range(0, 31), 16'($urandom),
            $urandom_range(0, 1), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom);
      cycle();
    end
    run_idle("rnd_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/or1200_vlx_packer.md
OR1200_VLX_PACKER -- requirements
Module: or1200_vlx_packer

Interface
REQ-001 Parameter ACC_W, default 32: bit-accumulator width; SHALL be >= MAXBITS+7.
REQ-002 Parameter MAXBITS, default 16: maximum bits appended per set-bit operation.
REQ-003 Parameter NB_W, default 5: width of num_bits_i; 2**NB_W > MAXBITS.
REQ-004 Parameter STUFF_DEF, default 1: reset value of the byte-stuff enable.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 Port clk_i, input, 1: clock, rising edge.
REQ-007 Port rst_ni, input, 1: asynchronous active-low reset.
REQ-008 Port set_bit_op_i, input, 1: append request, already qualified by PC advance.
REQ-009 Port num_bits_i, input, NB_W: number of bits to append.
REQ-010 Port dat_i, input, MAXBITS: bits to append, right-justified.
REQ-011 Port stall_cpu_o, output, 1: CPU stall request.
REQ-012 Port store_byte_o, output, 1: byte-store request to the data port.
REQ-013 Port vlx_addr_o, output, 32: byte address of the current store.
REQ-014 Port dat_o, output, 8: byte being stored.
REQ-015 Port ack_i, input, 1: store acknowledge.
REQ-016 Port spr_cs, input, 1: SPR select.
REQ-017 Port spr_write, input, 1: SPR write strobe.
REQ-018 Port spr_addr, input, 2: SPR register index.
REQ-019 Port spr_dat_i, input, 32: SPR write data.
REQ-020 Port spr_dat_o, output, 32: SPR read data.

Function
REQ-021 State: acc (ACC_W bits, MSB-first, valid bits left-aligned), cnt (0..ACC_W), addr (32 bits), stuff_en (1 bit), FSM state.
REQ-022 FSM states: IDLE, STORE, STUFF, PAD.
REQ-023 Accept: set_bit_op_i in IDLE with n = min(num_bits_i, MAXBITS) appends dat_i[n-1:0] at acc bit position ACC_W-1-cnt downward; cnt += n.
REQ-024 n = 0: no state change.
REQ-025 set_bit_op_i outside IDLE: ignored.
REQ-026 IDLE -> STORE on the edge after an accept, or in IDLE whenever cnt >= 8.
REQ-027 STORE: store_byte_o = 1; dat_o = acc[ACC_W-1:ACC_W-8]; vlx_addr_o = addr; all three held stable until ack_i.
REQ-028 STORE on ack_i: acc <<= 8 (zero fill); cnt -= 8; addr += 1, wrapping mod 2**32.
REQ-029 STORE on ack_i, next state: STUFF if stuff_en and stored byte = 8'hFF; else STORE if the new cnt >= 8; else IDLE.
REQ-030 STUFF: store_byte_o = 1, dat_o = 8'h00, vlx_addr_o = addr.
REQ-031 STUFF on ack_i: addr += 1; next state STORE if cnt >= 8, else IDLE.
REQ-032 stall_cpu_o = 1 whenever state != IDLE, or when an accept in the current cycle makes cnt + n >= 8 (combinational).
REQ-033 ack_i in IDLE: ignored.
REQ-034 ack_i in PAD: ignored.
REQ-035 SPR 0, RW: addr.
REQ-036 SPR 1, RO: {busy = (state != IDLE), zero-fill, cnt}.
REQ-037 SPR 2, W: bit0 = flush (self-clearing), bit1 = stuff_en; reads return {30'b0, stuff_en, 1'b0}.
REQ-038 SPR 3, RO: acc[ACC_W-1 -: 32], zero-extended if ACC_W < 32.
REQ-039 SPR read data is combinational.
REQ-040 SPR writes are accepted only in IDLE; writes in other states are dropped.
REQ-041 Flush in IDLE with cnt % 8 != 0: enter PAD.
REQ-042 Flush in IDLE with cnt = 0: no action.
REQ-043 PAD lasts one cycle: fill the remaining bits of the partial byte with 1s, round cnt up to a multiple of 8, then go to STORE.
REQ-044 Simultaneous set_bit_op_i and an SPR flush write in IDLE: the append is applied first, then the flush, in the same edge.
REQ-045 Simultaneous set_bit_op_i and an SPR addr write in IDLE: the SPR write is applied, and the store uses the new addr.

Reset
REQ-046 rst_ni low, asynchronously and in any state including mid-store: state = IDLE, acc = 0, cnt = 0, addr = 0, stuff_en = STUFF_DEF.
REQ-047 Outputs during reset: store_byte_o = 0, stall_cpu_o = 0, dat_o = 0, vlx_addr_o = 0.
REQ-048 A pending unacknowledged byte is discarded at reset.

Verification
REQ-049 Addr 0x1000; append (n=4, 0xA), then (n=4, 0x5); ack after 2 cycles -> one store: dat_o 0xA5 at 0x1000; addr becomes 0x1001; cnt 0.
REQ-050 stuff_en = 1; append (n=16, 0xFF12) -> stores 0xFF@A, 0x00@A+1, 0x12@A+2; stall_cpu_o high from the accept cycle until the final ack.
REQ-051 Append (n=3, 0b101); flush -> PAD, then store 0xBF; SPR1 then reads cnt 0, busy 0.
REQ-052 Addr 0xFFFFFFFF; append (n=8, 0x33) -> store at 0xFFFFFFFF; addr wraps to 0x00000000.
REQ-053 rst_ni low while in STORE awaiting ack -> store_byte_o drops immediately; SPR1 reads 0; a later ack_i has no effect.
REQ-054 num_bits_i = 31 with MAXBITS = 16 -> treated as 16 bits; two bytes stored.
